// File: rtl/div_seq_pkg.sv
// Shared constants for the divide sequencer: FSM encodings, handshake levels, widths.
package div_seq_pkg;

    localparam int RegWidth       = 32;
    localparam int DoubleRegWidth = 64;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;

endpackage

// File: rtl/div_iter.sv
// One radix-2 restoring step on the {remainder, quotient} working register.
// Pure combinational; the sequencer registers the result each cycle.
module div_iter #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH:0]  work,
    input  logic [WIDTH-1:0]  divisor,
    output logic [2*WIDTH:0]  work_next
);

    logic [2*WIDTH:0] shifted;
    logic [WIDTH:0]   diff;

    // Partial remainder is always below the divisor, so the shifted upper part
    // fits in WIDTH+1 bits and diff's top bit is a clean borrow flag.
    always_comb begin
        shifted = work << 1;
        diff    = shifted[2*WIDTH:WIDTH] - {1'b0, divisor};
        if (diff[WIDTH]) begin
            work_next = shifted;
        end else begin
            work_next = {diff, shifted[WIDTH-1:1], 1'b1};
        end
    end

endmodule

// File: rtl/div_seq.sv
// Multi-cycle DIV/DIVU sequencer: one quotient bit per cycle, sign fix-up, divide-by-zero and annul.
// Result lands 33 cycles after start (2 for divide-by-zero) and is held until start drops.
module div_seq
    import div_seq_pkg::*;
#(
    parameter int WIDTH = RegWidth
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 signed_div_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    input  logic                 start_i,
    input  logic                 annul_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o,
    output logic                 busy_o
);

    localparam int CntW = $clog2(WIDTH + 1);

    div_state_e        state;
    logic [CntW-1:0]   cnt;
    logic [2*WIDTH:0]  work;
    logic [2*WIDTH:0]  work_next;
    logic [WIDTH-1:0]  divisor;
    logic              neg_quot;
    logic              neg_rem;

    logic              go;
    logic              last_iter;
    logic [WIDTH-1:0]  dividend_abs;
    logic [WIDTH-1:0]  divisor_abs;
    logic [WIDTH-1:0]  quot_raw;
    logic [WIDTH-1:0]  rem_raw;
    logic [WIDTH-1:0]  quot_fix;
    logic [WIDTH-1:0]  rem_fix;

    assign go        = (start_i == DivStart) & ~annul_i;
    assign last_iter = (cnt == CntW'(WIDTH - 1));

    assign dividend_abs = (signed_div_i & opdata1_i[WIDTH-1]) ? (~opdata1_i + 1'b1) : opdata1_i;
    assign divisor_abs  = (signed_div_i & opdata2_i[WIDTH-1]) ? (~opdata2_i + 1'b1) : opdata2_i;

    // Fix-up is applied to the final step's output so the result registers at the ON->END edge.
    assign quot_raw = work_next[WIDTH-1:0];
    assign rem_raw  = work_next[2*WIDTH-1:WIDTH];
    assign quot_fix = neg_quot ? (~quot_raw + 1'b1) : quot_raw;
    assign rem_fix  = neg_rem  ? (~rem_raw + 1'b1)  : rem_raw;

    assign busy_o = ~rst & (((state == DivFree) & go) | (state == DivByZero) | (state == DivOn));

    div_iter #(.WIDTH(WIDTH)) u_div_iter (
        .work      (work),
        .divisor   (divisor),
        .work_next (work_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= DivFree;
            cnt      <= '0;
            work     <= '0;
            divisor  <= '0;
            neg_quot <= 1'b0;
            neg_rem  <= 1'b0;
            result_o <= '0;
            ready_o  <= DivResultNotReady;
        end else begin
            case (state)
                DivFree: begin
                    ready_o  <= DivResultNotReady;
                    result_o <= '0;
                    if (go) begin
                        if (opdata2_i == '0) begin
                            state <= DivByZero;
                        end else begin
                            state    <= DivOn;
                            cnt      <= '0;
                            work     <= {{(WIDTH + 1){1'b0}}, dividend_abs};
                            divisor  <= divisor_abs;
                            neg_quot <= signed_div_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                            neg_rem  <= signed_div_i & opdata1_i[WIDTH-1];
                        end
                    end
                end
                DivByZero: begin
                    state    <= DivEnd;
                    result_o <= '0;
                    ready_o  <= DivResultReady;
                end
                DivOn: begin
                    if (annul_i) begin
                        state <= DivFree;
                        cnt   <= '0;
                    end else begin
                        work <= work_next;
                        cnt  <= cnt + CntW'(1);
                        if (last_iter) begin
                            state    <= DivEnd;
                            result_o <= {rem_fix, quot_fix};
                            ready_o  <= DivResultReady;
                        end
                    end
                end
                DivEnd: begin
                    if (start_i == DivStop) begin
                        state    <= DivFree;
                        ready_o  <= DivResultNotReady;
                        result_o <= '0;
                    end
                end
                default: state <= DivFree;
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed corner cases plus random operands against an arithmetic model.
module tb_div_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        start;
    logic        annul;
    logic [63:0] result;
    logic        ready;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    div_seq #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div),
        .opdata1_i    (op1),
        .opdata2_i    (op2),
        .start_i      (start),
        .annul_i      (annul),
        .result_o     (result),
        .ready_o      (ready),
        .busy_o       (busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        longint q;
        longint r;
        logic [31:0] uq;
        logic [31:0] ur;
        if (b == 32'd0) return 64'd0;
        if (!sgn) begin
            uq = a / b;
            ur = a % b;
            return {ur, uq};
        end
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q  = sa / sb;
        r  = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Cycle 0 is the window in which start is first seen; operands are scrambled afterwards.
    task automatic run_div(input string tag, input bit sgn, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp);
        int n;
        int exp_lat;
        int busy_bad;
        bit seen;
        exp_lat    = (b == 32'd0) ? 2 : 33;
        signed_div = sgn;
        op1        = a;
        op2        = b;
        start      = 1'b1;
        #1;
        check({tag, "_busy_c0"}, 64'(busy), 64'd1);
        n        = 0;
        seen     = 1'b0;
        busy_bad = 0;
        while (!seen && n < 40) begin
            tick();
            n++;
            signed_div = 1'($urandom);
            op1        = $urandom;
            op2        = $urandom;
            #1;
            if (ready) seen = 1'b1;
            else if (!busy) busy_bad++;
        end
        check({tag, "_latency"}, 64'(n), 64'(exp_lat));
        check({tag, "_busy_gap"}, 64'(busy_bad), 64'd0);
        check({tag, "_result"}, result, exp);
        check({tag, "_busy_end"}, 64'(busy), 64'd0);
        start = 1'b0;
        tick();
        check({tag, "_ready_clr"}, 64'(ready), 64'd0);
        check({tag, "_result_clr"}, result, 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          sgn;
        logic [31:0] a;
        logic [31:0] b;
        int          ready_seen;

        rst        = 1'b1;
        start      = 1'b1;
        annul      = 1'b0;
        signed_div = 1'b0;
        op1        = 32'd7;
        op2        = 32'd2;
        repeat (3) tick();
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_ready", 64'(ready), 64'd0);
        check("reset_result", result, 64'd0);
        rst   = 1'b0;
        start = 1'b0;
        tick();

        run_div("u7_2", 1'b0, 32'd7, 32'd2, 64'h00000001_00000003);
        run_div("s_m7_2", 1'b1, 32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFF_FFFFFFFD);
        run_div("s_min_m1", 1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000);
        run_div("dz_5_0", 1'b0, 32'd5, 32'd0, 64'd0);
        run_div("dz_rearm", 1'b0, 32'd17, 32'd5, 64'h00000002_00000003);
        run_div("s_7_m2", 1'b1, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD);

        // Annul while in ON: EX drops start together with the flush.
        signed_div = 1'b0;
        op1        = 32'd1000;
        op2        = 32'd3;
        start      = 1'b1;
        repeat (10) tick();
        annul = 1'b1;
        start = 1'b0;
        #1;
        check("annul_busy_c10", 64'(busy), 64'd1);
        tick();
        annul = 1'b0;
        #1;
        check("annul_busy_c11", 64'(busy), 64'd0);
        ready_seen = 0;
        repeat (40) begin
            tick();
            if (ready) ready_seen++;
        end
        check("annul_no_ready", 64'(ready_seen), 64'd0);
        run_div("after_annul", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E);

        // start and annul together in IDLE: annul wins, nothing launches.
        op1   = 32'd50;
        op2   = 32'd5;
        start = 1'b1;
        annul = 1'b1;
        #1;
        check("idle_annul_busy0", 64'(busy), 64'd0);
        tick();
        check("idle_annul_busy1", 64'(busy), 64'd0);
        tick();
        check("idle_annul_ready", 64'(ready), 64'd0);
        start = 1'b0;
        annul = 1'b0;
        tick();

        // Reset in cycle 20 of an operation.
        signed_div = 1'b1;
        op1        = 32'h12345678;
        op2        = 32'd19;
        start      = 1'b1;
        repeat (20) tick();
        rst   = 1'b1;
        start = 1'b0;
        #1;
        check("rst_mid_busy", 64'(busy), 64'd0);
        tick();
        rst = 1'b0;
        #1;
        check("rst_after_ready", 64'(ready), 64'd0);
        check("rst_after_result", result, 64'd0);
        check("rst_after_busy", 64'(busy), 64'd0);
        run_div("after_rst", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003);

        for (int i = 0; i < 24; i++) begin
            sgn = 1'($urandom);
            a   = ($urandom_range(0, 3) == 0) ? 32'h80000000 : $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = 32'hFFFFFFFF;
                2:       b = $urandom_range(1, 15);
                default: b = $urandom;
            endcase
            run_div($sformatf("rnd%0d", i), sgn, a, b, model(sgn, a, b));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
